// File: rtl/pcie_sram_arbiter.sv
// Two-client (read/write) arbiter in front of a single-port SRAM.
// Grants are combinational. Bursts lock the SRAM to one client; a lock is cut short after MAX_LOCK beats if the other client waits.
module pcie_sram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 256,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_last,
  output logic              rd_gnt,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_gnt,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {ARB, LOCK_RD, LOCK_WR} state_t;

  localparam logic       WINNER_RD = 1'b0;
  localparam logic       WINNER_WR = 1'b1;
  localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK - 1);

  state_t     r_state;
  logic       r_last_winner;
  logic [7:0] r_lock_cnt;
  logic       r_rvalid;

  logic w_rd_sel;
  logic w_wr_sel;
  logic w_rd_gnt;
  logic w_wr_gnt;
  logic w_beat_last;
  logic w_other_req;
  logic w_release;

  always_comb begin
    w_rd_sel = 1'b0;
    w_wr_sel = 1'b0;
    case (r_state)
      ARB: begin
        if (rd_req && wr_req) begin
          w_rd_sel = (r_last_winner == WINNER_WR);
          w_wr_sel = (r_last_winner == WINNER_RD);
        end else begin
          w_rd_sel = rd_req;
          w_wr_sel = wr_req;
        end
      end
      LOCK_RD: w_rd_sel = rd_req;
      LOCK_WR: w_wr_sel = wr_req;
      default: ;
    endcase
  end

  // Grants are forced low while reset is asserted, not just after the next edge.
  assign w_rd_gnt = rst_n & w_rd_sel;
  assign w_wr_gnt = rst_n & w_wr_sel;

  // lock_cnt is always 0 in ARB, so the same release test covers lock entry and continuation.
  assign w_beat_last = w_rd_gnt ? rd_last : wr_last;
  assign w_other_req = w_rd_gnt ? wr_req : rd_req;
  assign w_release   = w_beat_last || ((r_lock_cnt == LOCK_LIMIT) && w_other_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ARB;
      r_last_winner <= WINNER_WR;
      r_lock_cnt    <= 8'd0;
      r_rvalid      <= 1'b0;
    end else begin
      r_rvalid <= w_rd_gnt;
      if (w_rd_gnt || w_wr_gnt) begin
        r_last_winner <= w_wr_gnt ? WINNER_WR : WINNER_RD;
        if (w_release) begin
          r_state    <= ARB;
          r_lock_cnt <= 8'd0;
        end else begin
          r_state <= w_rd_gnt ? LOCK_RD : LOCK_WR;
          if (r_lock_cnt != 8'hFF) begin
            r_lock_cnt <= r_lock_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign rd_gnt     = w_rd_gnt;
  assign wr_gnt     = w_wr_gnt;
  assign rd_rvalid  = r_rvalid;
  assign rd_rdata   = r_rvalid ? sram_rdata : '0;
  assign sram_en    = w_rd_gnt | w_wr_gnt;
  assign sram_we    = w_wr_gnt;
  assign sram_addr  = w_wr_gnt ? wr_addr : (w_rd_gnt ? rd_addr : '0);
  assign sram_wdata = w_wr_gnt ? wr_data : '0;

endmodule

// File: tb/tb_pcie_sram_arbiter.sv
// Directed bench for pcie_sram_arbiter: the driver queues the expected response for each cycle,
// and an independent monitor compares it at the falling edge.
module tb_pcie_sram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req = 1'b0, rd_last = 1'b0, wr_req = 1'b0, wr_last = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_gnt, rd_rvalid, wr_gnt, sram_en, sram_we;
  logic [DW-1:0] rd_rdata, sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [AW-1:0] sram_addr;

  always #5 clk = ~clk;

  pcie_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .wr_gnt(wr_gnt),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM, preloaded with 0xA000_0000 | address.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int a = 0; a < (1 << AW); a++) mem[a] = 32'hA000_0000 | 32'(a);
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  typedef struct {
    string         name;
    logic          rg, wg, en, we, rv;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rd;
    bit            chk_addr, chk_wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ok = (rd_gnt === e.rg) && (wr_gnt === e.wg) && (sram_en === e.en) && (sram_we === e.we) &&
             (rd_rvalid === e.rv) && (rd_rdata === e.rd) &&
             (!e.chk_addr || sram_addr === e.addr) && (!e.chk_wdata || sram_wdata === e.wdata);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s: got rg=%0b wg=%0b en=%0b we=%0b addr=%h wdata=%h rv=%0b rdata=%h; want rg=%0b wg=%0b en=%0b we=%0b addr=%h wdata=%h rv=%0b rdata=%h",
                   e.name, rd_gnt, wr_gnt, sram_en, sram_we, sram_addr, sram_wdata, rd_rvalid, rd_rdata,
                   e.rg, e.wg, e.en, e.we, e.addr, e.wdata, e.rv, e.rd);
        end else begin
          $display("%0t %s ok: rg=%0b wg=%0b rv=%0b rdata=%h", $time, e.name, rd_gnt, wr_gnt, rd_rvalid, rd_rdata);
        end
      end
    end
  end

  // One cycle of stimulus plus the hand-derived response for that cycle.
  task automatic step(input string nm, input bit rst_low,
                      input bit rr, input logic [AW-1:0] ra, input bit rl,
                      input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit wl,
                      input bit erg, input bit ewg, input bit erv, input logic [DW-1:0] erd);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = !rst_low;
    rd_req = rr; rd_addr = ra; rd_last = rl;
    wr_req = wr; wr_addr = wa; wr_data = wd; wr_last = wl;
    e.name = nm;
    if (rst_low) begin
      e.rg = 0; e.wg = 0; e.en = 0; e.we = 0; e.rv = 0;
      e.addr = '0; e.wdata = '0; e.rd = '0; e.chk_addr = 1; e.chk_wdata = 1;
    end else begin
      e.rg = erg; e.wg = ewg; e.en = erg | ewg; e.we = ewg; e.rv = erv; e.rd = erd;
      e.addr = ewg ? wa : ra; e.wdata = wd; e.chk_addr = erg | ewg; e.chk_wdata = ewg;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input bit erv, input logic [DW-1:0] erd);
    step(nm, 0, 0, '0, 0, 0, '0, '0, 0, 0, 0, erv, erd);
  endtask

  initial begin
    bit is_rd [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    bit prev_r;
    int b;
    int budget;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step("reset_hold", 1, 1, 10'h001, 1, 1, 10'h002, 32'h5, 1, 0, 0, 0, 0);
    step("reset_hold", 1, 1, 10'h001, 1, 1, 10'h002, 32'h5, 1, 0, 0, 0, 0);

    // Contention with single beats alternates, read first after reset.
    step("rr_c1_rd", 0, 1, 10'h010, 1, 1, 10'h020, 32'h1111_1111, 1, 1, 0, 0, 32'h0);
    step("rr_c2_wr", 0, 1, 10'h010, 1, 1, 10'h020, 32'h1111_1111, 1, 0, 1, 1, 32'hA000_0010);
    step("rr_c3_rd", 0, 1, 10'h010, 1, 1, 10'h020, 32'h1111_1111, 1, 1, 0, 0, 32'h0);
    step("rr_c4_wr", 0, 1, 10'h010, 1, 1, 10'h020, 32'h1111_1111, 1, 0, 1, 1, 32'hA000_0010);

    step("rd_single", 0, 1, 10'h005, 1, 0, '0, '0, 0, 1, 0, 0, 32'h0);
    idle("rd_single_data", 1, 32'hA000_0005);

    // Four-beat write burst holds off a waiting reader.
    for (int i = 0; i < 4; i++)
      step("wr_burst", 0, 1, 10'h020, 1, 1, 10'(10'h030 + i), 32'(32'hB0 + i), (i == 3), 0, 1, 0, 32'h0);
    step("wr_burst_then_rd", 0, 1, 10'h020, 1, 0, '0, '0, 0, 1, 0, 0, 32'h0);
    idle("wr_burst_rd_data", 1, 32'h1111_1111);

    // Ten-beat write burst with MAX_LOCK=4: the reader is let in after every fourth locked beat.
    b = 0;
    prev_r = 0;
    for (int i = 0; i < 12; i++) begin
      if (is_rd[i]) begin
        step("lock_max_rd", 0, 1, 10'h031, 1, 1, 10'(10'h040 + b), 32'(32'hC0 + b), (b == 9),
             1, 0, prev_r, prev_r ? 32'hB1 : 32'h0);
      end else begin
        step("lock_max_wr", 0, 1, 10'h031, 1, 1, 10'(10'h040 + b), 32'(32'hC0 + b), (b == 9),
             0, 1, prev_r, prev_r ? 32'hB1 : 32'h0);
        b++;
      end
      prev_r = is_rd[i];
    end
    idle("lock_max_idle", 0, 32'h0);

    // Read lock: the writer stays blocked while the reader is idle.
    step("rdlock_enter", 0, 1, 10'h040, 0, 1, 10'h050, 32'hDD, 1, 1, 0, 0, 32'h0);
    step("rdlock_idle1", 0, 0, 10'h040, 0, 1, 10'h050, 32'hDD, 1, 0, 0, 1, 32'hC0);
    step("rdlock_idle2", 0, 0, 10'h040, 0, 1, 10'h050, 32'hDD, 1, 0, 0, 0, 32'h0);
    step("rdlock_idle3", 0, 0, 10'h040, 0, 1, 10'h050, 32'hDD, 1, 0, 0, 0, 32'h0);
    step("rdlock_last",  0, 1, 10'h041, 1, 1, 10'h050, 32'hDD, 1, 1, 0, 0, 32'h0);
    step("rdlock_wr",    0, 0, 10'h041, 1, 1, 10'h050, 32'hDD, 1, 0, 1, 1, 32'hC1);
    idle("rdlock_idle", 0, 32'h0);

    // Reset during a write lock, then again with a read response pending.
    step("pre_rst_rd",  0, 1, 10'h050, 1, 0, '0, '0, 0, 1, 0, 0, 32'h0);
    step("pre_rst_wr",  0, 0, 10'h050, 1, 1, 10'h060, 32'hEE, 0, 0, 1, 1, 32'hDD);
    step("rst_in_lock", 1, 1, 10'h051, 1, 1, 10'h061, 32'hEF, 0, 0, 0, 0, 32'h0);
    step("rst_hold",    1, 1, 10'h051, 1, 1, 10'h061, 32'hEF, 0, 0, 0, 0, 32'h0);
    step("post_rst_rd", 0, 1, 10'h051, 1, 1, 10'h061, 32'hEF, 1, 1, 0, 0, 32'h0);
    step("rst_rv_kill", 1, 1, 10'h051, 1, 1, 10'h061, 32'hEF, 1, 0, 0, 0, 32'h0);
    step("post_rst2_rd", 0, 1, 10'h051, 1, 1, 10'h061, 32'hEF, 1, 1, 0, 0, 32'h0);
    step("post_rst2_wr", 0, 1, 10'h051, 1, 1, 10'h061, 32'hEF, 1, 0, 1, 1, 32'hA000_0051);
    idle("final_idle", 0, 32'h0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_sram_arbiter.md
PCIE_SRAM_ARBITER -- requirements
Module: pcie_sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM word address width.
REQ-002 Parameter DATA_W, default 256, SRAM data width.
REQ-003 Parameter MAX_LOCK, default 16, maximum consecutive locked grants to one client (range 1..255).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rd_req  input  1  read client request; held with rd_addr/rd_last until rd_gnt.
REQ-007 rd_addr  input  ADDR_W  read word address.
REQ-008 rd_last  input  1  final beat of read burst; 0 requests a lock.
REQ-009 rd_gnt  output  1  read beat accepted this cycle.
REQ-010 rd_rvalid  output  1  read data valid, exactly one cycle after the matching rd_gnt.
REQ-011 rd_rdata  output  DATA_W  read data, equal to sram_rdata while rd_rvalid=1.
REQ-012 wr_req  input  1  write client request; held with wr_addr/wr_data/wr_last until wr_gnt.
REQ-013 wr_addr  input  ADDR_W  write word address.
REQ-014 wr_data  input  DATA_W  write data.
REQ-015 wr_last  input  1  final beat of write burst; 0 requests a lock.
REQ-016 wr_gnt  output  1  write beat accepted and performed this cycle.
REQ-017 sram_en  output  1  SRAM access enable.
REQ-018 sram_we  output  1  1 = write, 0 = read; valid when sram_en=1.
REQ-019 sram_addr  output  ADDR_W  SRAM address.
REQ-020 sram_wdata  output  DATA_W  SRAM write data.
REQ-021 sram_rdata  input  DATA_W  SRAM read data, one-cycle latency after sram_en with sram_we=0.

Function
REQ-022 At most one of rd_gnt/wr_gnt SHALL be 1 in any cycle; gnt SHALL only assert while the corresponding req=1.
REQ-023 Grants and sram_en/sram_we/sram_addr/sram_wdata SHALL be combinational from req and registered state; the SRAM access occurs in the grant cycle.
REQ-024 On rd_gnt: sram_en=1, sram_we=0, sram_addr=rd_addr; on wr_gnt: sram_en=1, sram_we=1, sram_addr=wr_addr, sram_wdata=wr_data; otherwise sram_en=0, sram_we=0.
REQ-025 rd_rvalid SHALL be a register set to rd_gnt each cycle; back-to-back read grants yield back-to-back rd_rvalid.
REQ-026 State machine states: ARB, LOCK_RD, LOCK_WR.
REQ-027 ARB: single requester is granted; both requesting -> grant the client not in last_winner (round-robin register, reset value = write, so read wins first contention).
REQ-028 ARB: a grant with last=0 SHALL move to LOCK_RD/LOCK_WR and load lock_cnt=1; a grant with last=1 stays in ARB.
REQ-029 LOCK_x: only client x may be granted; the other client SHALL not be granted even if x is idle.
REQ-030 LOCK_x: grant with last=1 -> ARB; grant with last=0 -> lock_cnt+1.
REQ-031 LOCK_x: grant taken when lock_cnt==MAX_LOCK-1 and other client requesting -> ARB with last_winner=x (forced release), so the other client is granted next contention cycle; the remaining burst continues later through normal arbitration.
REQ-032 lock_cnt SHALL be 8 bits, saturate, and clear on every entry to ARB.
REQ-033 last_winner SHALL update on every grant.
REQ-034 Requests deasserted without grant SHALL not change state.

Reset
REQ-035 While rst_n=0: state=ARB, last_winner=write, lock_cnt=0, rd_rvalid=0, rd_gnt=0, wr_gnt=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, rd_rdata=0 (combinational outputs gated by rst_n).
REQ-036 Reset mid-burst SHALL abandon any lock and any pending rd_rvalid; first cycle after release behaves as ARB from reset.

Verification
REQ-037 Single read rd_req=1,rd_addr=0x005,rd_last=1 -> same-cycle rd_gnt=1,sram_en=1,sram_we=0,sram_addr=0x005; next cycle rd_rvalid=1,rd_rdata=sram_rdata.
REQ-038 rd_req and wr_req both 1, last=1, held 4 cycles after reset -> grants R,W,R,W; sram_we 0,1,0,1.
REQ-039 Write burst 4 beats (wr_last=0,0,0,1) with rd_req=1 throughout -> wr_gnt 4 consecutive cycles, rd_gnt=0 during them, rd_gnt on 5th cycle.
REQ-040 MAX_LOCK=4, write burst 10 beats, rd_req=1 -> 4 write grants, then 1 read grant, then writes resume; no cycle with both gnts.
REQ-041 Read lock entered (rd_last=0), rd_req drops 3 cycles while wr_req=1 -> wr_gnt stays 0; rd_req returns with rd_last=1 -> rd_gnt, then wr_gnt next cycle.
REQ-042 rst_n pulsed low during LOCK_WR with rd_rvalid pending -> all outputs 0 immediately; after release with both requesting, read granted first.
